// File: rtl/muxarr_pipe_pkg.sv
`default_nettype none
// muxarr_pipe_pkg: sizing helpers shared by the mux-array family.
// Rev 1.0
package muxarr_pipe_pkg;

  function automatic int clog2i(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int ceildiv(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Number of tree levels: select bits consumed RW at a time.
  function automatic int calc_nl(input int mw, input int rx);
    return ceildiv(clog2i(mw), clog2i(rx));
  endfunction

  function automatic int calc_mp(input int mw, input int rx);
    return 1 << (clog2i(rx) * calc_nl(mw, rx));
  endfunction

endpackage
`default_nettype wire

// File: rtl/muxarr_stage.sv
`default_nettype none
// muxarr_stage: one radix-RX tree level for NM channels with valid/ready register.
// Rev 1.0
module muxarr_stage
  import muxarr_pipe_pkg::*;
#(
  parameter int DW = 4,
  parameter int RX = 2,
  parameter int NW = 4,
  parameter int NM = 4,
  parameter int SP = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_vld,
  output logic                   o_rdy,
  input  logic [NW*NM*DW-1:0]    i_data,
  input  logic [NM*SP-1:0]       i_sel,
  output logic                   o_vld,
  input  logic                   i_rdy,
  output logic [NW/RX*NM*DW-1:0] o_data,
  output logic [NM*SP-1:0]       o_sel
);

  localparam int RW = clog2i(RX);
  localparam int NO = NW / RX;

  logic                 r_vld;
  logic [NO*NM*DW-1:0]  r_data;
  logic [NM*SP-1:0]     r_sel;
  logic [NO*NM*DW-1:0]  w_red;
  logic [NM*SP-1:0]     w_shf;

  assign o_rdy = !r_vld || i_rdy;

  // Low RW select bits pick one word of each RX group; the rest shift down.
  always_comb begin
    w_red = '0;
    w_shf = '0;
    for (int c = 0; c < NM; c++) begin
      for (int w = 0; w < NO; w++) begin
        w_red[(c*NO + w)*DW +: DW] =
          i_data[(c*NW + w*RX + int'(i_sel[c*SP +: RW]))*DW +: DW];
      end
      w_shf[c*SP +: SP] = i_sel[c*SP +: SP] >> RW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_data <= '0;
      r_sel  <= '0;
    end else if (o_rdy) begin
      r_vld <= i_vld;
      if (i_vld) begin
        r_data <= w_red;
        r_sel  <= w_shf;
      end
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;
  assign o_sel  = r_sel;

endmodule
`default_nettype wire

// File: rtl/muxarr_pipe.sv
`default_nettype none
// muxarr_pipe: NM packed MW:1 muxes as a pipelined radix-RX tree, valid/ready flow.
// Rev 1.0
module muxarr_pipe
  import muxarr_pipe_pkg::*;
#(
  parameter int DW = 4,
  parameter int MW = 4,
  parameter int NM = 4,
  parameter int RX = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  logic [DW*MW*NM-1:0]        inp,
  input  logic [clog2i(MW)*NM-1:0]   sel,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [DW*NM-1:0]           out
);

  localparam int SW = clog2i(MW);
  localparam int RW = clog2i(RX);
  localparam int NL = calc_nl(MW, RX);
  localparam int MP = calc_mp(MW, RX);
  localparam int SP = NL * RW;

  logic [MP*NM*DW-1:0] w_pad;
  logic [NM*SP-1:0]    w_selp;

  // Padding inputs are zero, so any select >= MW resolves to 0.
  for (genvar i = 0; i < NM; i++) begin : g_ch
    assign w_selp[i*SP +: SP] = SP'(sel[i*SW +: SW]);
    for (genvar j = 0; j < MP; j++) begin : g_in
      if (j < MW) begin : g_real
        assign w_pad[(i*MP + j)*DW +: DW] = inp[(i*MW + j)*DW +: DW];
      end else begin : g_zero
        assign w_pad[(i*MP + j)*DW +: DW] = '0;
      end
    end
  end

  for (genvar k = 0; k < NL; k++) begin : g_lvl
    localparam int NWI = MP / (RX ** k);
    localparam int NWO = NWI / RX;

    logic                 w_vin;
    logic                 w_rout;
    logic [NWI*NM*DW-1:0] w_din;
    logic [NM*SP-1:0]     w_sin;
    logic                 w_vout;
    logic                 w_rin;
    logic [NWO*NM*DW-1:0] w_dout;
    logic [NM*SP-1:0]     w_sout;

    if (k == 0) begin : g_head
      assign w_vin = in_vld;
      assign w_din = w_pad;
      assign w_sin = w_selp;
    end else begin : g_body
      assign w_vin = g_lvl[k-1].w_vout;
      assign w_din = g_lvl[k-1].w_dout;
      assign w_sin = g_lvl[k-1].w_sout;
    end

    if (k == NL - 1) begin : g_tail
      assign w_rin = out_rdy;
    end else begin : g_link
      assign w_rin = g_lvl[k+1].w_rout;
    end

    muxarr_stage #(
      .DW (DW),
      .RX (RX),
      .NW (NWI),
      .NM (NM),
      .SP (SP)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_vld  (w_vin),
      .o_rdy  (w_rout),
      .i_data (w_din),
      .i_sel  (w_sin),
      .o_vld  (w_vout),
      .i_rdy  (w_rin),
      .o_data (w_dout),
      .o_sel  (w_sout)
    );
  end

  assign in_rdy  = g_lvl[0].w_rout;
  assign out_vld = g_lvl[NL-1].w_vout;
  assign out     = out_vld ? g_lvl[NL-1].w_dout : '0;

endmodule
`default_nettype wire
